// File: rtl/input_dev_ctrl.sv
// Byte FIFO front end for the processor INPUT port; byte visible with in_dev_hs one edge after it lands, 3 cycles per byte,
// src_ready drops while the FIFO is full. Optional ack watchdog with sticky ack_timeout when INDEV_TIMEOUT_EN is defined.

module input_dev_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_dat,
  output logic [DATA_W-1:0] o_head,
  output logic [ADDR_W:0]   o_count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_dat;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

module input_dev_ctrl #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              g_clk,
  input  logic              g_clr,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic [DATA_W-1:0] input_bus,
  output logic              in_dev_hs,
  input  logic              in_dev_ack,
  output logic [ADDR_W:0]   fifo_count,
  output logic              ack_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_load;
  logic              w_src_rdy;
  logic [DATA_W-1:0] w_head;
  logic [ADDR_W:0]   w_count;
  logic [DATA_W-1:0] r_bus;
  logic              r_hs;

  assign w_src_rdy = (w_count != (ADDR_W + 1)'(DEPTH));
  assign w_push    = src_valid && w_src_rdy;

  input_dev_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .i_clk   (g_clk),
    .i_rst_n (g_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (src_data),
    .o_head  (w_head),
    .o_count (w_count)
  );

`ifdef INDEV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_ack_to;
  logic             w_tmo_hit;
`endif

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // The head byte stays in the FIFO while presented; it is popped on ack (or on expiry).
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pop       = 1'b0;
`ifdef INDEV_TIMEOUT_EN
    w_tmo_hit   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_count != '0) begin
          w_load      = 1'b1;
          w_state_nxt = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (in_dev_ack) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_RELEASE;
        end
`ifdef INDEV_TIMEOUT_EN
        else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          w_pop       = 1'b1;
          w_tmo_hit   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`endif
      end
      ST_RELEASE: begin
        if (!in_dev_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      r_bus <= '0;
      r_hs  <= 1'b0;
    end else begin
      if (w_load) begin
        r_bus <= w_head;
        r_hs  <= 1'b1;
      end else if (w_pop) begin
        r_hs  <= 1'b0;
      end
    end
  end

`ifdef INDEV_TIMEOUT_EN
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      r_tmo_cnt <= '0;
      r_ack_to  <= 1'b0;
    end else begin
      if (w_load)                       r_tmo_cnt <= '0;
      else if (r_state == ST_PRESENT)   r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_tmo_hit)                    r_ack_to  <= 1'b1;
    end
  end

  assign ack_timeout = r_ack_to;
`else
  assign ack_timeout = 1'b0;
`endif

  assign src_ready  = w_src_rdy;
  assign input_bus  = r_bus;
  assign in_dev_hs  = r_hs;
  assign fifo_count = w_count;

endmodule

// File: tb/tb_input_dev_ctrl.sv
// Scoreboard bench for input_dev_ctrl: bytes queued as accepted, compared as each is presented.
// Timeout scenario runs only when INDEV_TIMEOUT_EN is defined (then TIMEOUT=4).

module tb_input_dev_ctrl;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
`ifdef INDEV_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic              g_clk      = 1'b0;
  logic              g_clr      = 1'b1;
  logic              src_valid  = 1'b0;
  logic [DATA_W-1:0] src_data   = '0;
  logic              in_dev_ack = 1'b0;
  logic              src_ready;
  logic [DATA_W-1:0] input_bus;
  logic              in_dev_hs;
  logic [ADDR_W:0]   fifo_count;
  logic              ack_timeout;

  input_dev_ctrl #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TMO)
  ) dut (
    .g_clk       (g_clk),
    .g_clr       (g_clr),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .input_bus   (input_bus),
    .in_dev_hs   (in_dev_hs),
    .in_dev_ack  (in_dev_ack),
    .fifo_count  (fifo_count),
    .ack_timeout (ack_timeout)
  );

  always #5 g_clk = ~g_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: occupancy, handshake phase and the queue of bytes not yet presented.
  logic [DATA_W-1:0] sb_q [$];
  int m_cnt = 0;
  int m_st  = 0;
  int m_tc  = 0;
  bit m_to  = 1'b0;

  always @(posedge g_clk or negedge g_clr) begin : model
    bit push;
    bit pop;
    if (!g_clr) begin
      m_cnt = 0;
      m_st  = 0;
      m_tc  = 0;
      m_to  = 1'b0;
      sb_q.delete();
    end else begin
      push = src_valid && (m_cnt != DEPTH);
      pop  = 1'b0;
      case (m_st)
        0: if (m_cnt != 0) begin m_st = 1; m_tc = 0; end
        1: begin
          if (in_dev_ack) begin
            pop = 1'b1; m_st = 2;
          end
`ifdef INDEV_TIMEOUT_EN
          else if (m_tc == TMO - 1) begin
            pop = 1'b1; m_st = 0; m_to = 1'b1;
          end else m_tc++;
`endif
        end
        default: if (!in_dev_ack) m_st = 0;
      endcase
      if (push) sb_q.push_back(src_data);
      m_cnt = m_cnt + int'(push) - int'(pop);
    end
  end

  bit mon_en  = 1'b0;
  bit prev_hs = 1'b0;

  always @(negedge g_clk) begin
    if (mon_en && g_clr) begin
      chk("hs_model", in_dev_hs, m_st == 1);
      chk("count_model", fifo_count, m_cnt);
      chk("timeout_model", ack_timeout, m_to);
      if (in_dev_hs && !prev_hs) begin
        chk("sb_avail", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) chk("sb_data", input_bus, sb_q.pop_front());
      end
    end
    prev_hs = in_dev_hs;
  end

  task automatic push_byte(input logic [DATA_W-1:0] d);
    src_valid = 1'b1;
    src_data  = d;
    @(negedge g_clk);
    src_valid = 1'b0;
  endtask

  task automatic wait_hs(input logic v, input string tag);
    int n = 0;
    while (in_dev_hs !== v && n < 64) begin
      @(negedge g_clk);
      n++;
    end
    chk(tag, in_dev_hs, v);
  endtask

  task automatic handshake();
    wait_hs(1'b1, "hs_rise");
    in_dev_ack = 1'b1;
    wait_hs(1'b0, "hs_fall");
    in_dev_ack = 1'b0;
    @(negedge g_clk);
  endtask

  initial begin : watchdog
    #200000;
    n_err++;
    $display("FAIL watchdog: run did not complete");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    #3 g_clr = 1'b0;
    #1;
    chk("rst_hs", in_dev_hs, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_bus", input_bus, 0);
    chk("rst_timeout", ack_timeout, 0);
    repeat (2) @(negedge g_clk);
    g_clr  = 1'b1;
    mon_en = 1'b1;
    @(negedge g_clk);
    chk("rst_ready", src_ready, 1);

    // Single byte latency and four-phase release.
    src_valid = 1'b1;
    src_data  = 8'hA5;
    @(negedge g_clk);
    src_valid = 1'b0;
    chk("single_cnt1", fifo_count, 1);
    chk("single_hs_early", in_dev_hs, 0);
    @(negedge g_clk);
    chk("single_hs", in_dev_hs, 1);
    chk("single_bus", input_bus, 8'hA5);
    in_dev_ack = 1'b1;
    @(negedge g_clk);
    chk("single_hs_drop", in_dev_hs, 0);
    chk("single_cnt0", fifo_count, 0);
    in_dev_ack = 1'b0;
    repeat (2) @(negedge g_clk);
    chk("single_idle_hs", in_dev_hs, 0);
    chk("single_bus_hold", input_bus, 8'hA5);

    // Reset in the middle of a presentation with bytes queued.
    push_byte(8'h61);
    push_byte(8'h62);
    push_byte(8'h63);
    chk("midrst_hs_before", in_dev_hs, 1);
    chk("midrst_cnt_before", fifo_count, 3);
    g_clr = 1'b0;
    #1;
    chk("midrst_hs", in_dev_hs, 0);
    chk("midrst_cnt", fifo_count, 0);
    @(negedge g_clk);
    g_clr = 1'b1;
    @(negedge g_clk);
    chk("midrst_ready", src_ready, 1);
    chk("midrst_hs_after", in_dev_hs, 0);

`ifndef INDEV_TIMEOUT_EN
    // Fill to full, refuse a ninth byte, then drain across the pointer wrap.
    for (int i = 1; i <= 8; i++) push_byte(i[7:0]);
    chk("fill_cnt", fifo_count, 8);
    chk("fill_ready", src_ready, 0);
    src_valid = 1'b1;
    src_data  = 8'h99;
    @(negedge g_clk);
    src_valid = 1'b0;
    chk("fill_9th", fifo_count, 8);
    repeat (8) handshake();
    chk("fill_drained", fifo_count, 0);
`endif

    // Ack held high: exactly one byte consumed until ack falls.
    push_byte(8'h11);
    push_byte(8'h22);
    wait_hs(1'b1, "stuck_hs_rise");
    in_dev_ack = 1'b1;
    repeat (8) @(negedge g_clk);
    chk("stuck_one_pop", fifo_count, 1);
    chk("stuck_hs_low", in_dev_hs, 0);
    in_dev_ack = 1'b0;
    handshake();
    chk("stuck_drained", fifo_count, 0);

`ifndef INDEV_TIMEOUT_EN
    // Pop at full (push blocked) and push+pop at one entry.
    for (int i = 0; i < 8; i++) push_byte(8'h40 + i[7:0]);
    wait_hs(1'b1, "full_hs");
    src_valid  = 1'b1;
    src_data   = 8'h48;
    in_dev_ack = 1'b1;
    @(negedge g_clk);
    src_valid  = 1'b0;
    in_dev_ack = 1'b0;
    chk("full_pop_cnt", fifo_count, 7);
    for (int k = 0; k < 10 && m_cnt > 1; k++) handshake();
    wait_hs(1'b1, "one_hs");
    src_valid  = 1'b1;
    src_data   = 8'h55;
    in_dev_ack = 1'b1;
    @(negedge g_clk);
    src_valid  = 1'b0;
    in_dev_ack = 1'b0;
    chk("pushpop_cnt", fifo_count, 1);
    handshake();
    chk("pushpop_drained", fifo_count, 0);
`else
    // Unanswered byte expires after TIMEOUT cycles; the next one is served normally.
    push_byte(8'h3C);
    wait_hs(1'b1, "tmo_hs_rise");
    begin
      int n = 0;
      while (in_dev_hs && n < 20) begin
        @(negedge g_clk);
        n++;
      end
      chk("tmo_cycles", n, TMO);
    end
    chk("tmo_flag", ack_timeout, 1);
    chk("tmo_cnt", fifo_count, 0);
    push_byte(8'h3D);
    handshake();
    chk("tmo_flag_sticky", ack_timeout, 1);
    chk("tmo_drained", fifo_count, 0);
`endif

    repeat (3) @(negedge g_clk);
    chk("end_sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
